// File: rtl/cursor_pkg.sv
// Shared definitions for the mouse cursor path:
// OLED geometry, coordinate widths, tracker states, RGB565 colours.
package cursor_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int CX_W   = 7;
  localparam int CY_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALE_X,
    ST_SCALE_Y,
    ST_UPDATE
  } trk_state_e;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// The start cycle performs the first step, so done rises DIV_W cycles later.
module serial_divider #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] src_rem;
  logic [DIV_W-1:0] src_quo;
  logic [DIV_W:0]   d_ext;
  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    src_rem = rem_q;
    src_quo = quo_q;
    d_ext   = {1'b0, dsr_q};
    if (start) begin
      src_rem = '0;
      src_quo = dividend;
      dsr_d   = divisor;
      d_ext   = {1'b0, divisor};
    end
    trial = {src_rem, src_quo[DIV_W-1]};
    diff  = trial - d_ext;
    if (start || run_q) begin
      if (trial >= d_ext) begin
        rem_d = diff[DIV_W-1:0];
        quo_d = {src_quo[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIV_W-1:0];
        quo_d = {src_quo[DIV_W-2:0], 1'b0};
      end
    end
    if (start) begin
      cnt_d = CNT_W'(DIV_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Scales raw MouseCtl positions to OLED pixels with a shared serial divider,
// coalesces events that arrive while busy, and edge-detects the buttons.
module mouse_cursor_tracker
  import cursor_pkg::*;
#(
  parameter int X_RANGE = 640,
  parameter int Y_RANGE = 480,
  parameter int DIV_W   = 19
) (
  input  logic            basys_clock,
  input  logic            rst_n,
  input  logic [11:0]     xpos,
  input  logic [11:0]     ypos,
  input  logic            left,
  input  logic            middle,
  input  logic            right,
  input  logic            new_event,
  output logic [CX_W-1:0] cursor_x,
  output logic [CY_W-1:0] cursor_y,
  output logic            pos_valid,
  output logic            left_press,
  output logic            right_press,
  output logic            middle_press,
  output logic            cursor_mode,
  output logic            busy
);

  localparam logic [DIV_W-1:0] X_MAX = DIV_W'(OLED_W - 1);
  localparam logic [DIV_W-1:0] Y_MAX = DIV_W'(OLED_H - 1);

  trk_state_e       state_q, state_d;
  logic             pend_q, pend_d;
  logic [11:0]      ylat_q, ylat_d;
  logic [DIV_W-1:0] qx_q, qx_d;
  logic [CX_W-1:0]  cx_q, cx_d;
  logic [CY_W-1:0]  cy_q, cy_d;
  logic             pv_q, pv_d;

  logic             div_start;
  logic [DIV_W-1:0] div_dvd;
  logic [DIV_W-1:0] div_dsr;
  logic             div_done;
  logic [DIV_W-1:0] div_quo;

  logic l_prev_q, m_prev_q, r_prev_q;
  logic l_pr_q, m_pr_q, r_pr_q;
  logic mode_q, mode_d;

  serial_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (basys_clock),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (div_dsr),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ylat_d    = ylat_q;
    qx_d      = qx_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    pv_d      = 1'b0;
    div_start = 1'b0;
    div_dvd   = '0;
    div_dsr   = '0;
    // Events seen while busy collapse into a single re-capture.
    if (state_q != ST_IDLE && new_event) pend_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (new_event || pend_q) begin
          ylat_d    = ypos;
          pend_d    = 1'b0;
          div_start = 1'b1;
          div_dvd   = DIV_W'(xpos) * DIV_W'(OLED_W);
          div_dsr   = DIV_W'(X_RANGE);
          state_d   = ST_SCALE_X;
        end
      end
      ST_SCALE_X: begin
        if (div_done) begin
          qx_d      = div_quo;
          div_start = 1'b1;
          div_dvd   = DIV_W'(ylat_q) * DIV_W'(OLED_H);
          div_dsr   = DIV_W'(Y_RANGE);
          state_d   = ST_SCALE_Y;
        end
      end
      ST_SCALE_Y: begin
        if (div_done) begin
          cx_d = (qx_q > X_MAX) ? CX_W'(OLED_W - 1) : qx_q[CX_W-1:0];
          cy_d = (div_quo > Y_MAX) ? CY_W'(OLED_H - 1) : div_quo[CY_W-1:0];
          pv_d    = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      ylat_q  <= '0;
      qx_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ylat_q  <= ylat_d;
      qx_q    <= qx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      pv_q    <= pv_d;
    end
  end

  assign mode_d = mode_q ^ (middle & ~m_prev_q);

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      l_prev_q <= 1'b0;
      m_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
      l_pr_q   <= 1'b0;
      m_pr_q   <= 1'b0;
      r_pr_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      l_prev_q <= left;
      m_prev_q <= middle;
      r_prev_q <= right;
      l_pr_q   <= left & ~l_prev_q;
      m_pr_q   <= middle & ~m_prev_q;
      r_pr_q   <= right & ~r_prev_q;
      mode_q   <= mode_d;
    end
  end

  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign pos_valid    = pv_q;
  assign left_press   = l_pr_q;
  assign middle_press = m_pr_q;
  assign right_press  = r_pr_q;
  assign cursor_mode  = mode_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed and randomized checks of mouse_cursor_tracker
// against an arithmetic model of the pixel scaling.
module tb_mouse_cursor_tracker;

  localparam int DIV_W = 19;
  localparam int XR    = 640;
  localparam int YR    = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        left = 1'b0;
  logic        middle = 1'b0;
  logic        right = 1'b0;
  logic        new_event = 1'b0;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        pos_valid;
  logic        left_press;
  logic        right_press;
  logic        middle_press;
  logic        cursor_mode;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mouse_cursor_tracker #(
    .X_RANGE(XR), .Y_RANGE(YR), .DIV_W(DIV_W)
  ) dut (
    .basys_clock  (clk),
    .rst_n        (rst_n),
    .xpos         (xpos),
    .ypos         (ypos),
    .left         (left),
    .middle       (middle),
    .right        (right),
    .new_event    (new_event),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .pos_valid    (pos_valid),
    .left_press   (left_press),
    .right_press  (right_press),
    .middle_press (middle_press),
    .cursor_mode  (cursor_mode),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_x(input int x);
    int q = (x * 96) / XR;
    return (q > 95) ? 95 : q;
  endfunction

  function automatic int model_y(input int y);
    int q = (y * 64) / YR;
    return (q > 63) ? 63 : q;
  endfunction

  task automatic conv(input int x, input int y);
    int n;
    bit busy_ok;
    xpos = 12'(x);
    ypos = 12'(y);
    new_event = 1'b1;
    tick();
    new_event = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (pos_valid !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk("latency", n, 2 * DIV_W);
    chk("busy_span", 32'(busy_ok), 1);
    chk("cursor_x", 32'(cursor_x), model_x(x));
    chk("cursor_y", 32'(cursor_y), model_y(y));
    tick();
    chk("strobe_len", 32'(pos_valid), 0);
    chk("idle_after", 32'(busy), 0);
  endtask

  initial begin
    int pv_cnt, mp_cnt, lp_cnt, rp_cnt;
    int sx[$];
    int sy[$];
    int x, y;

    // reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pv", 32'(pos_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pos_valid === 1'b1) pv_cnt++;
    end
    chk("no_event_pv", pv_cnt, 0);
    chk("rst_cx", 32'(cursor_x), 0);
    chk("rst_cy", 32'(cursor_y), 0);
    chk("rst_mode", 32'(cursor_mode), 0);

    conv(320, 240);
    conv(639, 479);
    conv(4095, 4095);
    conv(640, 480);
    conv(0, 0);

    // coalescing: initial event plus three while busy
    xpos = 12'd320;
    ypos = 12'd240;
    new_event = 1'b1;
    tick();
    new_event = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      new_event = 1'b0;
      if (i == 5) begin
        xpos = 12'd500; ypos = 12'd400; new_event = 1'b1;
      end else if (i == 10) begin
        xpos = 12'd300; ypos = 12'd300; new_event = 1'b1;
      end else if (i == 15) begin
        xpos = 12'd100; ypos = 12'd200; new_event = 1'b1;
      end
      tick();
      if (pos_valid === 1'b1) begin
        sx.push_back(int'(cursor_x));
        sy.push_back(int'(cursor_y));
      end
    end
    new_event = 1'b0;
    chk("coalesce_cnt", sx.size(), 2);
    if (sx.size() == 2) begin
      chk("coal_x0", sx[0], 48);
      chk("coal_y0", sy[0], 32);
      chk("coal_x1", sx[1], model_x(100));
      chk("coal_y1", sy[1], model_y(200));
    end

    // randomized positions, half inside range, half anywhere
    for (int i = 0; i < 12; i++) begin
      if ($urandom % 2 == 0) begin
        x = int'($urandom_range(0, XR - 1));
        y = int'($urandom_range(0, YR - 1));
      end else begin
        x = int'($urandom_range(0, 4095));
        y = int'($urandom_range(0, 4095));
      end
      conv(x, y);
    end

    // buttons
    mp_cnt = 0;
    middle = 1'b1;
    tick();
    chk("mode_first", 32'(cursor_mode), 1);
    chk("mpress_first", 32'(middle_press), 1);
    for (int i = 0; i < 30; i++) begin
      if (middle_press === 1'b1) mp_cnt++;
      if (i == 9) middle = 1'b0;
      if (i == 15) middle = 1'b1;
      if (i == 18) middle = 1'b0;
      tick();
    end
    chk("mpress_cnt", mp_cnt, 2);
    chk("mode_second", 32'(cursor_mode), 0);

    lp_cnt = 0;
    rp_cnt = 0;
    left = 1'b1;
    right = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (left_press === 1'b1) lp_cnt++;
      if (right_press === 1'b1) rp_cnt++;
    end
    left = 1'b0;
    right = 1'b0;
    chk("lpress_cnt", lp_cnt, 1);
    chk("rpress_cnt", rp_cnt, 1);

    // reset during a conversion
    middle = 1'b1;
    tick();
    middle = 1'b0;
    tick();
    chk("mode_pre_rst", 32'(cursor_mode), 1);
    conv(320, 240);
    xpos = 12'd600;
    ypos = 12'd400;
    new_event = 1'b1;
    tick();
    new_event = 1'b0;
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cx", 32'(cursor_x), 0);
    chk("mid_rst_cy", 32'(cursor_y), 0);
    chk("mid_rst_mode", 32'(cursor_mode), 0);
    chk("mid_rst_pv", 32'(pos_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pv_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pos_valid === 1'b1) pv_cnt++;
    end
    chk("post_rst_pv", pv_cnt, 0);
    conv(639, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
